// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control unit FSM with retired-instruction counter
module mc_ctrl #(
  parameter bit MEM_HS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [2:0]       npc_sel,
  output logic [1:0]       ext_op,
  output logic [3:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    WB_ALU = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_MEM = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t stateReg;
  state_t nextState;

  logic isRtype, isAddu, isSubu, isSlt, isJr;
  logic isOri, isLui, isLw, isSw, isAddi, isAddiu, isBeq, isJ, isJal;
  logic isIType, isAluOp, grant;
  logic [3:0] aluOpCode;
  logic [1:0] extCode;

  // Instruction decode from the held IR fields
  always_comb begin
    isRtype = (opcode == 6'b000000);
    isAddu  = isRtype && (funct == 6'b100001);
    isSubu  = isRtype && (funct == 6'b100011);
    isSlt   = isRtype && (funct == 6'b101010);
    isJr    = isRtype && (funct == 6'b001000);
    isOri   = (opcode == 6'b001101);
    isLui   = (opcode == 6'b001111);
    isLw    = (opcode == 6'b100011);
    isSw    = (opcode == 6'b101011);
    isAddi  = (opcode == 6'b001000);
    isAddiu = (opcode == 6'b001001);
    isBeq   = (opcode == 6'b000100);
    isJ     = (opcode == 6'b000010);
    isJal   = (opcode == 6'b000011);
    isIType = isOri || isLui || isAddi || isAddiu;
    isAluOp = isAddu || isSubu || isSlt || isIType;
    // Without the handshake every memory access is granted immediately
    grant   = !MEM_HS || mem_ready;
  end

  // ALU operation and immediate extension for the arithmetic group
  always_comb begin
    aluOpCode = 4'b0000;
    extCode   = 2'b00;
    if (isSubu)       aluOpCode = 4'b0001;
    else if (isSlt)   aluOpCode = 4'b0110;
    else if (isOri)   aluOpCode = 4'b0010;
    else if (isLui) begin
      aluOpCode = 4'b0011;
      extCode   = 2'b10;
    end else if (isAddi) begin
      aluOpCode = 4'b0101;
      extCode   = 2'b01;
    end else if (isAddiu) begin
      aluOpCode = 4'b0000;
      extCode   = 2'b01;
    end
  end

  // Next-state and control outputs; reset overrides every enable and pulse
  always_comb begin
    nextState  = stateReg;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    npc_sel    = 3'b000;
    ext_op     = 2'b00;
    alu_ctrl   = 4'b0000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (stateReg)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        if (grant) begin
          pc_write  = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        if (isAluOp)                nextState = EXEC;
        else if (isLw || isSw)      nextState = ADDR;
        else if (isBeq)             nextState = BRANCH;
        else if (isJ || isJal || isJr) nextState = JUMP;
        else begin
          illegal   = 1'b1;
          nextState = FETCH;
        end
      end
      EXEC: begin
        alu_ctrl  = aluOpCode;
        alu_src   = isIType;
        ext_op    = extCode;
        nextState = WB_ALU;
      end
      WB_ALU: begin
        alu_ctrl   = aluOpCode;
        alu_src    = isIType;
        ext_op     = extCode;
        reg_write  = 1'b1;
        reg_dst    = isIType ? 2'b00 : 2'b01;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      ADDR: begin
        alu_src   = 1'b1;
        ext_op    = 2'b01;
        nextState = isLw ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        if (grant) nextState = WB_MEM;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        wd_sel     = 2'b01;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        if (grant) begin
          instr_done = 1'b1;
          nextState  = FETCH;
        end
      end
      BRANCH: begin
        alu_ctrl   = 4'b0001;
        npc_sel    = 3'b001;
        pc_write   = alu_zero;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
        if (isJal) begin
          npc_sel   = 3'b010;
          reg_write = 1'b1;
          reg_dst   = 2'b10;
          wd_sel    = 2'b10;
        end else if (isJr) begin
          npc_sel  = 3'b100;
          alu_ctrl = 4'b0100;
        end else begin
          npc_sel = 3'b011;
        end
      end
      default: nextState = FETCH;
    endcase
    if (reset) begin
      nextState  = FETCH;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= FETCH;
      instr_cnt <= '0;
    end else begin
      stateReg <= nextState;
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign state = stateReg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl with an instruction-level reference model
module tb_mc_ctrl;

  localparam int CNT_W = 2;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_BEQ = 4;
  localparam int K_J   = 5;
  localparam int K_JAL = 6;
  localparam int K_JR  = 7;
  localparam int K_ILL = 8;

  typedef struct packed {
    logic       pcW, irW, regW, memR, memW, aluSrc;
    logic [1:0] regDst, wdSel;
    logic [2:0] npc;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       done, ill;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic memReady, aluZero;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, alu_src;
  logic [1:0] reg_dst, wd_sel, ext_op;
  logic [2:0] npc_sel;
  logic [3:0] alu_ctrl, state;
  logic instr_done, illegal;
  logic [CNT_W-1:0] instr_cnt;

  int checks = 0;
  int failures = 0;
  int expCnt = 0;

  logic [5:0] tOp [13];
  logic [5:0] tFn [13];
  int         tKind [13];
  logic [3:0] tAlu [13];
  logic [1:0] tExt [13];

  ctrl_t obs;
  assign obs = {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
                reg_dst, wd_sel, npc_sel, ext_op, alu_ctrl, instr_done, illegal};

  mc_ctrl #(.MEM_HS(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(memReady), .alu_zero(aluZero),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel), .ext_op(ext_op),
    .alu_ctrl(alu_ctrl), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic setEntry(input int i, input logic [5:0] op, input logic [5:0] fn,
                          input int kind, input logic [3:0] alu, input logic [1:0] ext);
    tOp[i] = op; tFn[i] = fn; tKind[i] = kind; tAlu[i] = alu; tExt[i] = ext;
  endtask

  function automatic bit isLegal(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 13; i++)
      if (tOp[i] == op && (op != 6'd0 || tFn[i] == fn)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs at negedge, check outputs, retire into the model
  task automatic step(input logic [3:0] expState, input ctrl_t c, input logic [5:0] op,
                      input logic [5:0] fn, input logic mr, input logic az, input string tag);
    @(negedge clk);
    opcode = op; funct = fn; memReady = mr; aluZero = az;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(expState));
    chk({tag, "_ctrl"}, 32'(obs), 32'(c));
    chk({tag, "_cnt"}, 32'(instr_cnt), 32'(expCnt));
    if (c.done) expCnt = (expCnt + 1) % (1 << CNT_W);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction from its class
  task automatic playInstr(input logic [5:0] op, input logic [5:0] fn, input int kind,
                           input logic [3:0] alu, input logic [1:0] ext,
                           input int fw, input int mw, input logic az);
    ctrl_t c;
    for (int i = 0; i < fw; i++) begin
      c = '0; c.memR = 1; c.irW = 1;
      step(4'd0, c, op, fn, 1'b0, rb(), "fetch_wait");
    end
    c = '0; c.memR = 1; c.irW = 1; c.pcW = 1;
    step(4'd0, c, op, fn, 1'b1, rb(), "fetch");
    c = '0; c.ill = (kind == K_ILL);
    step(4'd1, c, op, fn, rb(), rb(), "decode");
    case (kind)
      K_R, K_I: begin
        c = '0; c.alu = alu; c.ext = ext; c.aluSrc = (kind == K_I);
        step(4'd2, c, op, fn, rb(), rb(), "exec");
        c.regW = 1; c.regDst = (kind == K_R) ? 2'b01 : 2'b00; c.done = 1;
        step(4'd3, c, op, fn, rb(), rb(), "wb_alu");
      end
      K_LW: begin
        c = '0; c.aluSrc = 1; c.ext = 2'b01;
        step(4'd4, c, op, fn, rb(), rb(), "addr");
        c = '0; c.memR = 1;
        for (int i = 0; i < mw; i++) step(4'd5, c, op, fn, 1'b0, rb(), "mem_rd_wait");
        step(4'd5, c, op, fn, 1'b1, rb(), "mem_rd");
        c = '0; c.regW = 1; c.wdSel = 2'b01; c.done = 1;
        step(4'd7, c, op, fn, rb(), rb(), "wb_mem");
      end
      K_SW: begin
        c = '0; c.aluSrc = 1; c.ext = 2'b01;
        step(4'd4, c, op, fn, rb(), rb(), "addr");
        c = '0; c.memW = 1;
        for (int i = 0; i < mw; i++) step(4'd6, c, op, fn, 1'b0, rb(), "mem_wr_wait");
        c.done = 1;
        step(4'd6, c, op, fn, 1'b1, rb(), "mem_wr");
      end
      K_BEQ: begin
        c = '0; c.alu = 4'b0001; c.npc = 3'b001; c.pcW = az; c.done = 1;
        step(4'd8, c, op, fn, rb(), az, "branch");
      end
      K_J: begin
        c = '0; c.pcW = 1; c.npc = 3'b011; c.done = 1;
        step(4'd9, c, op, fn, rb(), rb(), "jump_j");
      end
      K_JAL: begin
        c = '0; c.pcW = 1; c.npc = 3'b010; c.regW = 1; c.regDst = 2'b10;
        c.wdSel = 2'b10; c.done = 1;
        step(4'd9, c, op, fn, rb(), rb(), "jump_jal");
      end
      K_JR: begin
        c = '0; c.pcW = 1; c.npc = 3'b100; c.alu = 4'b0100; c.done = 1;
        step(4'd9, c, op, fn, rb(), rb(), "jump_jr");
      end
      default: ;
    endcase
  endtask

  task automatic playIdx(input int i, input int fw, input int mw, input logic az);
    logic [5:0] fn;
    fn = (tOp[i] == 6'd0) ? tFn[i] : 6'($urandom);
    playInstr(tOp[i], fn, tKind[i], tAlu[i], tExt[i], fw, mw, az);
  endtask

  initial begin
    ctrl_t c;
    logic [5:0] op, fn;
    setEntry(0,  6'b000000, 6'b100001, K_R,   4'b0000, 2'b00); // ADDU
    setEntry(1,  6'b000000, 6'b100011, K_R,   4'b0001, 2'b00); // SUBU
    setEntry(2,  6'b000000, 6'b101010, K_R,   4'b0110, 2'b00); // SLT
    setEntry(3,  6'b000000, 6'b001000, K_JR,  4'b0100, 2'b00); // JR
    setEntry(4,  6'b001101, 6'b000000, K_I,   4'b0010, 2'b00); // ORI
    setEntry(5,  6'b001111, 6'b000000, K_I,   4'b0011, 2'b10); // LUI
    setEntry(6,  6'b100011, 6'b000000, K_LW,  4'b0000, 2'b01); // LW
    setEntry(7,  6'b101011, 6'b000000, K_SW,  4'b0000, 2'b01); // SW
    setEntry(8,  6'b001000, 6'b000000, K_I,   4'b0101, 2'b01); // ADDI
    setEntry(9,  6'b001001, 6'b000000, K_I,   4'b0000, 2'b01); // ADDIU
    setEntry(10, 6'b000100, 6'b000000, K_BEQ, 4'b0001, 2'b00); // BEQ
    setEntry(11, 6'b000010, 6'b000000, K_J,   4'b0000, 2'b00); // J
    setEntry(12, 6'b000011, 6'b000000, K_JAL, 4'b0000, 2'b00); // JAL

    reset = 1'b1; opcode = 6'b000000; funct = 6'b100001; memReady = 1'b1; aluZero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_enables", 32'({pc_write, ir_write, reg_write, mem_read, mem_write,
                              instr_done, illegal}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    expCnt = 0;

    // Directed: ADDU, LW with 3 waits, BEQ taken/not taken (count wraps), JAL, illegal
    playIdx(0, 0, 0, 1'b0);
    playIdx(6, 0, 3, 1'b0);
    playIdx(10, 0, 0, 1'b1);
    playIdx(10, 0, 0, 1'b0);
    playIdx(12, 0, 0, 1'b0);
    playInstr(6'b111111, 6'd0, K_ILL, 4'd0, 2'd0, 0, 0, 1'b0);
    playInstr(6'b000000, 6'b100000, K_ILL, 4'd0, 2'd0, 1, 0, 1'b0);

    // Randomized instruction stream with random handshake waits
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 13);
      if (r == 13) begin
        op = 6'b111111; fn = 6'd0;
        for (int k = 0; k < 50; k++) begin
          logic [5:0] o2, f2;
          o2 = 6'($urandom); f2 = 6'($urandom);
          if (!isLegal(o2, f2)) begin op = o2; fn = f2; break; end
        end
        playInstr(op, fn, K_ILL, 4'd0, 2'd0, $urandom_range(0, 2), 0, 1'b0);
      end else begin
        playIdx(r, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      end
    end

    // Reset during a pending MEM_WR wait abandons the store
    c = '0; c.memR = 1; c.irW = 1; c.pcW = 1;
    step(4'd0, c, tOp[7], 6'd0, 1'b1, 1'b0, "sw_fetch");
    c = '0;
    step(4'd1, c, tOp[7], 6'd0, 1'b0, 1'b0, "sw_decode");
    c = '0; c.aluSrc = 1; c.ext = 2'b01;
    step(4'd4, c, tOp[7], 6'd0, 1'b0, 1'b0, "sw_addr");
    c = '0; c.memW = 1;
    step(4'd6, c, tOp[7], 6'd0, 1'b0, 1'b0, "sw_wait");
    @(negedge clk);
    reset = 1'b1; memReady = 1'b0;
    #1;
    chk("rst_memwr_drop", 32'(mem_write), 32'd0);
    chk("rst_memwr_enables", 32'({pc_write, ir_write, reg_write, mem_read, mem_write,
                                  instr_done, illegal}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_release_state", 32'(state), 32'd0);
    chk("rst_release_cnt", 32'(instr_cnt), 32'd0);
    expCnt = 0;
    playIdx(0, 0, 0, 1'b0);
    playIdx(7, 2, 1, 1'b0);

    @(negedge clk); #1;
    chk("final_cnt", 32'(instr_cnt), 32'(expCnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_HS, default 1, 1 = memory states wait for mem_ready, 0 = every memory access completes in one cycle and mem_ready is ignored.
REQ-002 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  6  instruction bits [31:26] from the external IR, stable from DECODE until the instruction ends.
REQ-006 funct  in  6  instruction bits [5:0].
REQ-007 mem_ready  in  1  memory completion handshake, sampled in FETCH, MEM_RD and MEM_WR.
REQ-008 alu_zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-009 pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  write/read enables.
REQ-010 alu_src  out  1  1 = ALU B operand is the extended immediate.
REQ-011 reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
REQ-012 wd_sel  out  2  00 = ALU, 01 = memory, 10 = PC+4.
REQ-013 npc_sel  out  3  000 = PC+4, 001 = branch, 010 = JAL, 011 = J, 100 = JR.
REQ-014 ext_op  out  2  00 = zero-extend, 01 = sign-extend, 10 = load-upper.
REQ-015 alu_ctrl  out  4  0000 addu, 0001 subu, 0010 or, 0011 pass B, 0100 pass A, 0101 add, 0110 set-less-than.
REQ-016 state  out  4  current FSM state encoding.
REQ-017 instr_done  out  1  one-cycle pulse on the final cycle of each legal instruction.
REQ-018 illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
REQ-019 instr_cnt  out  CNT_W  count of retired instructions.

Function
REQ-020 Supported instructions SHALL be: R-type (opcode 000000) ADDU 100001, SUBU 100011, SLT 101010, JR 001000; ORI 001101; LUI 001111; LW 100011; SW 101011; ADDI 001000; ADDIU 001001; BEQ 000100; J 000010; JAL 000011.
REQ-021 State SHALL be registered; all other outputs SHALL be combinational from state, opcode and funct; any output not listed for a state SHALL be 0.
REQ-022 FETCH (0): mem_read=1, ir_write=1; on grant (mem_ready=1, or MEM_HS=0) pc_write=1, npc_sel=000 and next state DECODE; otherwise stay in FETCH.
REQ-023 DECODE (1): R-type arithmetic, ORI, LUI, ADDI and ADDIU go to EXEC; LW/SW to ADDR; BEQ to BRANCH; J, JAL and JR to JUMP; anything else pulses illegal and returns to FETCH with no writes.
REQ-024 EXEC (2) goes to WB_ALU; alu_ctrl per REQ-015 (ADDIU=0000, ADDI=0101, ORI=0010, LUI=0011); alu_src=1 for I-type; ext_op ORI=00, LUI=10, ADDI/ADDIU=01.
REQ-025 WB_ALU (3): EXEC's alu controls held; reg_write=1, wd_sel=00, reg_dst=01 for R-type and 00 for I-type; next state FETCH.
REQ-026 ADDR (4): alu_ctrl=0000, alu_src=1, ext_op=01; LW goes to MEM_RD, SW to MEM_WR.
REQ-027 MEM_RD (5): mem_read=1, held until grant, then WB_MEM.
REQ-028 WB_MEM (7): reg_write=1, wd_sel=01, reg_dst=00, then FETCH.
REQ-029 MEM_WR (6): mem_write=1, held until grant, then FETCH.
REQ-030 BRANCH (8): alu_ctrl=0001; npc_sel=001; pc_write=alu_zero; then FETCH.
REQ-031 JUMP (9): pc_write=1; J gives npc_sel=011; JAL gives npc_sel=010 with reg_write=1, reg_dst=10, wd_sel=10; JR gives npc_sel=100, alu_ctrl=0100; then FETCH.
REQ-032 instr_done SHALL assert in the cycle whose next state is FETCH, excluding illegal exits; instr_cnt SHALL increment on that edge and wrap from 2^CNT_W-1 to 0.
REQ-033 Latency: ALU ops 4 cycles, LW 5, SW 4, BEQ/J/JAL/JR 3, plus wait cycles when MEM_HS=1.

Reset
REQ-034 While reset=1, the next state SHALL be FETCH, instr_cnt SHALL clear to 0, and all enables, instr_done and illegal SHALL be forced to 0.
REQ-035 Reset asserted mid-instruction (including a pending memory wait) SHALL abandon the instruction with no further writes; the first cycle after release SHALL be FETCH.

Verification
REQ-036 ADDU with mem_ready=1: states 0,1,2,3; in state 3 reg_write=1, reg_dst=01, alu_ctrl=0000; instr_cnt becomes 1.
REQ-037 LW with mem_ready low for 3 cycles in MEM_RD: MEM_RD lasts 4 cycles with mem_read=1, then WB_MEM with wd_sel=01.
REQ-038 BEQ with alu_zero=1 gives pc_write=1, npc_sel=001; with alu_zero=0, pc_write=0; both end in FETCH with instr_done=1.
REQ-039 JAL in JUMP gives reg_dst=10, wd_sel=10, npc_sel=010; opcode 111111 pulses illegal, instr_cnt unchanged.
REQ-040 Reset during a MEM_WR wait drops mem_write the same cycle; with CNT_W=2, four retired instructions return instr_cnt to 0.
